// File: rtl/pent_video_pkg.sv
// pent_video_pkg: Pentagon video timing defaults, counter widths and sync FSM encoding
// Shared by the sync decoder and the timing generator.
package pent_video_pkg;
   localparam int H_TOTAL_DEF = 896;
   localparam int V_TOTAL_DEF = 320;
   localparam int HCNT_W      = 10;
   localparam int VCNT_W      = 9;
   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, HOLD} sync_state_t;
endpackage

// File: rtl/pent_sync2ff.sv
// pent_sync2ff: 1-bit two-flop synchronizer
// Ports: clk (destination clock), rst (async active-high), d (async input), q (synchronized output)
module pent_sync2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, m} <= 2'b00;
      else {q, m} <= {m, d};
endmodule

// File: rtl/pent_sync_dec.sv
// pent_sync_dec: Pentagon ssi/ksi sync decoder with line/frame counters and lock tracking
// Ports:
//   clk14m               14 MHz pixel clock
//   rst                  asynchronous active-high reset
//   ssi, ksi, bl         raw line sync, frame sync, blanking (asynchronous to clk14m)
//   hcnt, vcnt           clocks since line_start, lines since frame_start
//   line_start           one-clock pulse per accepted ssi rising edge
//   frame_start          one-clock pulse per accepted ksi rising edge
//   active               synchronized ~bl, aligned with hcnt
//   locked               high while the lock FSM is in LOCKED
//   h_err, v_err         line / frame length violation pulses
module pent_sync_dec
   import pent_video_pkg::*;
#(
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int H_TOL       = 2,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              clk14m,
   input  logic              rst,
   input  logic              ssi,
   input  logic              ksi,
   input  logic              bl,
   output logic [HCNT_W-1:0] hcnt,
   output logic [VCNT_W-1:0] vcnt,
   output logic              line_start,
   output logic              frame_start,
   output logic              active,
   output logic              locked,
   output logic              h_err,
   output logic              v_err
);
   localparam int HW1 = HCNT_W + 1;
   localparam int VW1 = VCNT_W + 1;
   localparam int GW  = $clog2(LOCK_FRAMES + 1);
   localparam logic [HCNT_W:0] H_MIN = HW1'(H_TOTAL - H_TOL);
   localparam logic [HCNT_W:0] H_MAX = HW1'(H_TOTAL + H_TOL);
   localparam logic [VCNT_W:0] V_LEN = VW1'(V_TOTAL);
   logic ssi_s, ksi_s, bl_s, ssi_d, ksi_d;
   logic lrise, frise, herr_c, verr_c, good_c, hmax_c, bad_c;
   logic h_seen, v_seen, fbad, pend;
   logic [HCNT_W-1:0] hn;
   logic [VCNT_W-1:0] vn;
   logic [HCNT_W:0]   hlen;
   logic [VCNT_W:0]   vlen;
   logic [GW-1:0]     gcnt, gcnt_n;
   sync_state_t       state, state_n;

   pent_sync2ff u_ssi (.clk(clk14m), .rst(rst), .d(ssi), .q(ssi_s));
   pent_sync2ff u_ksi (.clk(clk14m), .rst(rst), .d(ksi), .q(ksi_s));
   pent_sync2ff u_bl  (.clk(clk14m), .rst(rst), .d(bl),  .q(bl_s));

   assign lrise  = ssi_s & ~ssi_d;
   assign frise  = ksi_s & ~ksi_d;
   // lengths use the pre-clear count, so a period of N clocks measures N
   assign hlen   = HW1'(hcnt) + HW1'(1);
   assign vlen   = VW1'(vcnt) + VW1'(1);
   assign hn     = lrise ? '0 : hcnt + HCNT_W'(~&hcnt);
   assign vn     = frise ? '0 : vcnt + VCNT_W'(lrise & ~&vcnt);
   assign hmax_c = &hn;
   assign herr_c = lrise & h_seen & ((hlen < H_MIN) | (hlen > H_MAX));
   assign verr_c = frise & v_seen & (vlen != V_LEN);
   assign bad_c  = herr_c | verr_c;
   assign good_c = frise & ~fbad & ~bad_c;
   assign gcnt_n = (state == SEARCH) ? '0 : (state == ACQUIRE && good_c) ? gcnt + GW'(1) : gcnt;
   assign locked = state == LOCKED;

   // HOLD: pend marks that the frame which caused the drop has not ended yet;
   // only frames after it are judged good (relock) or bad (give up)
   always_comb begin
      state_n = state;
      case (state)
         SEARCH:  state_n = frise ? ACQUIRE : SEARCH;
         ACQUIRE: state_n = bad_c ? SEARCH : (good_c && gcnt == GW'(LOCK_FRAMES - 1)) ? LOCKED : ACQUIRE;
         LOCKED:  state_n = hmax_c ? SEARCH : bad_c ? HOLD : LOCKED;
         HOLD:    state_n = hmax_c ? SEARCH : pend ? HOLD : (bad_c | (frise & fbad)) ? SEARCH : good_c ? LOCKED : HOLD;
         default: state_n = SEARCH;
      endcase
   end

   always_ff @(posedge clk14m or posedge rst)
      if (rst) begin
         ssi_d       <= 1'b0;
         ksi_d       <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         active      <= 1'b0;
         h_err       <= 1'b0;
         v_err       <= 1'b0;
         state       <= SEARCH;
         gcnt        <= '0;
         h_seen      <= 1'b0;
         v_seen      <= 1'b0;
         fbad        <= 1'b0;
         pend        <= 1'b0;
      end else begin
         ssi_d       <= ssi_s;
         ksi_d       <= ksi_s;
         hcnt        <= hn;
         vcnt        <= vn;
         line_start  <= lrise;
         frame_start <= frise;
         active      <= ~bl_s;
         h_err       <= herr_c;
         v_err       <= verr_c;
         state       <= state_n;
         gcnt        <= gcnt_n;
         // re-entering SEARCH forgets the line reference so the next line is not judged
         h_seen      <= (state_n == SEARCH && state != SEARCH) ? 1'b0 : h_seen | lrise;
         v_seen      <= v_seen | frise;
         fbad        <= ~frise & (fbad | herr_c);
         pend        <= (state == LOCKED && state_n == HOLD) ? ~frise : pend & ~frise;
      end
endmodule

// File: tb/tb_pent_sync_dec.sv
// tb_pent_sync_dec: directed stimulus with a behavioural reference model for pent_sync_dec
module tb_pent_sync_dec;
   localparam int H_T = 896;
   localparam int V_T = 4;
   localparam int TOL = 2;
   localparam int LF  = 2;
   localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCKED = 2, M_HOLD = 3;

   logic clk14m = 1'b0;
   logic rst, ssi, ksi, bl;
   logic [9:0] hcnt;
   logic [8:0] vcnt;
   logic line_start, frame_start, active, locked, h_err, v_err;

   pent_sync_dec #(.H_TOTAL(H_T), .V_TOTAL(V_T), .H_TOL(TOL), .LOCK_FRAMES(LF)) dut (
      .clk14m(clk14m), .rst(rst), .ssi(ssi), .ksi(ksi), .bl(bl),
      .hcnt(hcnt), .vcnt(vcnt), .line_start(line_start), .frame_start(frame_start),
      .active(active), .locked(locked), .h_err(h_err), .v_err(v_err)
   );

   always #5 clk14m = ~clk14m;

   int total = 0;
   int bad = 0;
   int nprint = 0;

   // reference model state
   bit [3:0] sd, kd, bd;
   bit e_ls, e_fs, e_ac, e_he, e_ve, hs, vs, fb, pend, sat, good, badf;
   int mh, mv, st, old, gc, len, flen;
   logic [24:0] act, expv;

   // snapshots taken by the line driver around each line_start
   logic [9:0] p_h, s_h;
   logic [8:0] p_v, s_v;
   logic s_ls, s_fs, s_he, s_ve, s_lk;

   task automatic chk(input string nm, input int a, input int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, a, e);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         sd = '0; kd = '0; bd = '0;
         e_ls = 0; e_fs = 0; e_ac = 0; e_he = 0; e_ve = 0;
         hs = 0; vs = 0; fb = 0; pend = 0;
         mh = 0; mv = 0; st = M_SEARCH; gc = 0;
      end else begin
         sd = {sd[2:0], ssi};
         kd = {kd[2:0], ksi};
         bd = {bd[2:0], bl};
         e_ls = sd[2] & ~sd[3];
         e_fs = kd[2] & ~kd[3];
         e_ac = ~bd[2];
         len  = mh + 1;
         flen = mv + 1;
         e_he = e_ls && hs && (len < H_T - TOL || len > H_T + TOL);
         e_ve = e_fs && vs && flen != V_T;
         mh = e_ls ? 0 : (mh < 1023 ? mh + 1 : 1023);
         mv = e_fs ? 0 : e_ls ? (mv < 511 ? mv + 1 : 511) : mv;
         sat  = !e_ls && mh == 1023;
         badf = e_he || e_ve;
         good = e_fs && !fb && !badf;
         old = st;
         case (st)
            M_SEARCH: if (e_fs) st = M_ACQ;
            M_ACQ:
               if (badf) st = M_SEARCH;
               else if (good) begin
                  gc++;
                  if (gc == LF) st = M_LOCKED;
               end
            M_LOCKED:
               if (sat) st = M_SEARCH;
               else if (badf) begin
                  st = M_HOLD;
                  pend = !e_fs;
               end
            default:
               if (sat) st = M_SEARCH;
               else if (pend) begin
                  if (e_fs) pend = 0;
               end else if (badf || (e_fs && fb)) st = M_SEARCH;
               else if (good) st = M_LOCKED;
         endcase
         if (st == M_SEARCH) gc = 0;
         fb = e_fs ? 0 : (fb | e_he);
         hs = (st == M_SEARCH && old != M_SEARCH) ? 0 : (hs | e_ls);
         vs = vs | e_fs;
      end
   endtask

   task automatic line(input int n, input bit fr);
      ssi = 1'b1; ksi = fr; bl = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk14m);
         if (i == 1) begin p_h = hcnt; p_v = vcnt; end
         if (i == 2) begin
            s_ls = line_start; s_fs = frame_start; s_h = hcnt; s_v = vcnt;
            s_he = h_err; s_ve = v_err; s_lk = locked;
         end
         if (i == 63) begin ssi = 1'b0; ksi = 1'b0; end
         if (i == 159) bl = 1'b0;
      end
   endtask

   task automatic lines(input int cnt, input int n);
      for (int i = 0; i < cnt; i++) line(n, 1'b0);
   endtask

   task automatic run();
      rst = 1'b1; ssi = 1'b0; ksi = 1'b0; bl = 1'b0;
      repeat (3) @(negedge clk14m);
      chk("reset_outputs", {hcnt, vcnt, line_start, frame_start, active, locked, h_err, v_err}, 0);
      rst = 1'b0;
      @(negedge clk14m);
      line(H_T, 1);
      chk("f1_line_start", s_ls, 1);
      chk("f1_frame_start", s_fs, 1);
      chk("f1_hcnt_vcnt", {s_h, s_v}, 0);
      chk("f1_locked", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("f2_hcnt_max", p_h, 895);
      chk("f2_vcnt_max", p_v, V_T - 1);
      chk("f2_errors", {s_he, s_ve}, 0);
      chk("f2_locked", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("f3_locked", s_lk, 1);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      line(900, 0);
      line(H_T, 0);
      chk("long_line_len", p_h, 899);
      chk("long_line_herr", s_he, 1);
      chk("long_line_unlock", s_lk, 0);
      line(H_T, 0);
      line(H_T, 1);
      chk("hold_bad_frame_end", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("hold_relock", s_lk, 1);
      line(H_T, 0);
      repeat (1100) @(negedge clk14m);
      chk("ssi_lost_hcnt", hcnt, 1023);
      chk("ssi_lost_locked", locked, 0);
      line(897, 1);
      line(898, 0);
      chk("tol_897", s_he, 0);
      line(894, 0);
      chk("tol_898", s_he, 0);
      line(H_T, 0);
      chk("tol_894", s_he, 0);
      line(H_T, 1);
      chk("acq_frame_good", {s_he, s_ve, s_lk}, 0);
      lines(V_T - 2, H_T);
      line(H_T, 1);
      chk("short_frame_verr", s_ve, 1);
      chk("short_frame_locked", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("research_acq", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("research_one_good", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("research_locked", s_lk, 1);
      line(400, 0);
      chk("pre_reset_locked", locked, 1);
      rst = 1'b1;
      #1;
      chk("mid_reset_outputs", {hcnt, vcnt, line_start, frame_start, active, locked, h_err, v_err}, 0);
      repeat (3) @(negedge clk14m);
      rst = 1'b0;
      line(H_T, 1);
      chk("post_rst_f1", {s_he, s_ve, s_lk}, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("post_rst_f2", s_lk, 0);
      lines(V_T - 1, H_T);
      line(H_T, 1);
      chk("post_rst_relock", s_lk, 1);
      lines(1, H_T);
   endtask

   initial begin
      fork
         forever begin
            @(posedge clk14m);
            model_step();
            #1;
            act  = {line_start, frame_start, hcnt, vcnt, active, locked, h_err, v_err};
            expv = {e_ls, e_fs, 10'(mh), 9'(mv), e_ac, st == M_LOCKED, e_he, e_ve};
            total++;
            if (act !== expv) begin
               bad++;
               if (nprint < 20) begin
                  nprint++;
                  $display("FAIL cycle_compare t=%0t: got ls=%b fs=%b h=%0d v=%0d act=%b lk=%b he=%b ve=%b want ls=%b fs=%b h=%0d v=%0d act=%b lk=%b he=%b ve=%b",
                     $time, line_start, frame_start, hcnt, vcnt, active, locked, h_err, v_err,
                     e_ls, e_fs, mh, mv, e_ac, st == M_LOCKED, e_he, e_ve);
               end
            end
         end
         run();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
